// File: rtl/mips_muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e    : operation encoding carried on the op port
//   md_state_e : controller state encoding (IDLE -> CALC -> FIXUP -> IDLE)
package mips_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10
  } md_state_e;

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   acc_i    : working accumulator
//              MUL: {partial product high half, remaining multiplier bits}
//              DIV: {partial remainder, remaining dividend bits / quotient so far}
//   opnd_i   : multiplicand (MUL) or divisor (DIV), magnitude
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_o    : accumulator after this iteration (DIV: LSB left 0, see qbit_o)
//   qbit_o   : quotient bit produced by this divide step (0 for MUL)
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_n;

  always_comb begin
    // Multiply: conditionally add the multiplicand into the top half, keep the carry.
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
           + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
    // Divide: bring the next dividend bit into a WIDTH+1 bit partial remainder.
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, opnd_i});
    // After a successful subtract the remainder is below the divisor, so it fits WIDTH bits.
    rem_n  = fits ? WIDTH'(rem_sh - {1'b0, opnd_i}) : rem_sh[WIDTH-1:0];

    acc_o  = {sum, acc_i[WIDTH-1:1]};
    qbit_o = 1'b0;
    if (is_div_i) begin
      acc_o  = {rem_n, acc_i[WIDTH-2:0], 1'b0};
      qbit_o = fits;
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline.
// Operands are converted to magnitudes at launch, WIDTH radix-2 steps run in CALC,
// and FIXUP spends two cycles: apply result signs, then write HI/LO and pulse done.
//   clk, rst      : clock, asynchronous active-high reset
//   start, op     : launch MULT/MULTU/DIV/DIVU (sampled only while idle)
//   a, b          : rs / rt operands
//   hi_we, lo_we  : MTHI / MTLO strobes with wdata (honoured only while idle)
//   flush         : abort an in-flight operation, HI/LO left untouched
//   busy          : operation in flight
//   done          : one-cycle pulse when HI/LO were just written by an operation
//   hi, lo        : HI / LO registers
module mips_muldiv_unit
  import mips_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  // Control state (reset)
  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Working datapath (no reset; always loaded at launch)
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;   // negate product / quotient
  logic               neg_r_q, neg_r_d;   // remainder takes negative dividend sign

  // Launch-time operand decode
  md_op_e             op_e;
  logic               op_div, op_signed, sgn_a, sgn_b, div_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign op_e      = md_op_e'(op);
  assign op_div    = (op_e == MD_DIV)  || (op_e == MD_DIVU);
  assign op_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign sgn_a     = op_signed & a[WIDTH-1];
  assign sgn_b     = op_signed & b[WIDTH-1];
  assign mag_a     = sgn_a ? neg_w(a) : a;
  assign mag_b     = sgn_b ? neg_w(b) : b;
  // Divide by zero: the restoring loop naturally yields remainder=|a| and an all-ones
  // quotient; suppressing the quotient negation and giving the remainder the dividend
  // sign reproduces hi=a, lo=all ones.
  assign div_zero  = op_div && (b == '0);

  logic [2*WIDTH-1:0] step_acc;
  logic               step_qbit;

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc),
    .qbit_o   (step_qbit)
  );

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  assign prod_fix = neg_q_q ? neg_2w(acc_q) : acc_q;
  assign rem_fix  = neg_r_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  assign quo_fix  = neg_q_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;

    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
          opnd_d   = op_div ? mag_b : mag_a;
          is_div_d = op_div;
          neg_q_d  = (sgn_a ^ sgn_b) & ~div_zero;
          neg_r_d  = op_div & sgn_a;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_qbit};
          if (cnt_q == LAST_STEP) begin
            state_d = ST_FIXUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FIXUP: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          // First FIXUP cycle: apply signs in place.
          acc_d = is_div_q ? {rem_fix, quo_fix} : prod_fix;
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Second FIXUP cycle: commit to HI/LO.
          hi_d    = acc_q[2*WIDTH-1:WIDTH];
          lo_d    = acc_q[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    neg_q_q  <= neg_q_d;
    neg_r_q  <= neg_r_d;
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32): directed corner cases plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_mips_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {hi,lo} from ordinary 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    longint      sx, sy, q, m;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: r = sx * sy;
      2'b01: r = {32'b0, x} * {32'b0, y};
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // Launch one operation and check latency, result and handshake.
  // poke >= 0: at that cycle drive start+MTHI/MTLO while busy (must be ignored).
  // mt: assert MTHI together with start (write lands, result later overwrites).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int poke, input bit mt, input string tag);
    int          cyc;
    logic [63:0] e;
    logic [31:0] wv;
    e  = ref_md(o, x, y);
    wv = $urandom;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (mt) begin hi_we = 1'b1; wdata = wv; end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; a = $urandom; b = $urandom;
    chk({tag, "_busy"}, busy, 1);
    if (mt) chk({tag, "_mthi_start"}, hi, wv);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      if (cyc == poke) begin
        start = 1'b1; op = 2'($urandom); hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk({tag, "_lat"}, cyc, LAT);
    chk({tag, "_hilo"}, {hi, lo}, e);
    chk({tag, "_idle"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done1"}, done, 0);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  // Launch then flush after k cycles; nothing may be written.
  task automatic flush_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int k, input string tag);
    int cyc;
    bit seen;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < k) begin @(negedge clk); cyc++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    chk({tag, "_nodone"}, seen, 0);
    chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] v);
    @(negedge clk);
    if (to_hi) hi_we = 1'b1; else lo_we = 1'b1;
    wdata = v;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (to_hi) m_hi = v; else m_lo = v;
  endtask

  initial begin
    bit          seen;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;

    mt_write(1'b1, 32'h1111_2222);
    chk("mthi", {hi, lo}, {m_hi, m_lo});
    mt_write(1'b0, 32'h3333_4444);
    chk("mtlo", {hi, lo}, {m_hi, m_lo});

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, "multu_max");
    chk("multu_max_val", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, 0, "mult_neg");
    chk("mult_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, 0, "mult_minmin");
    chk("mult_minmin_val", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 0, "div_neg");
    chk("div_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd7, 32'd2, -1, 0, "divu_7_2");
    chk("divu_7_2_val", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, "div_ovf");
    chk("div_ovf_val", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(2'b11, 32'h1234_5678, 32'd0, -1, 0, "divu_z");
    chk("divu_z_val", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op(2'b10, 32'h1234_5678, 32'd0, -1, 0, "div_z");
    chk("div_z_val", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, -1, 0, "div_negz");
    run_op(2'b10, 32'd9, 32'hFFFF_FFFC, -1, 0, "div_posneg");

    run_op(2'b01, 32'h0001_0003, 32'h0000_0105, 3, 0, "busy_poke");
    run_op(2'b00, 32'hFFFF_0000, 32'h0000_1234, -1, 1, "mt_start");

    // start together with flush is dropped
    @(negedge clk);
    op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("startflush_busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    chk("startflush_nodone", seen, 0);
    chk("startflush_hilo", {hi, lo}, {m_hi, m_lo});

    // flush while idle
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("idleflush_busy", busy, 0);
    chk("idleflush_hilo", {hi, lo}, {m_hi, m_lo});

    mt_write(1'b1, 32'hAAAA_0000);
    chk("preload_hi", hi, 32'hAAAA_0000);
    flush_op(2'b00, 32'h0000_0003, 32'h0000_0007, 10, "flush_calc");
    chk("flush_calc_hi", hi, 32'hAAAA_0000);
    flush_op(2'b10, 32'h0000_0064, 32'h0000_0007, LAT - 1, "flush_fixup");

    // asynchronous reset in the middle of a DIVU
    run_op(2'b11, 32'd1000, 32'd7, -1, 0, "pre_rst");
    @(negedge clk);
    op = 2'b11; a = 32'hDEAD_BEEF; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0; m_hi = '0; m_lo = '0;
    run_op(2'b11, 32'hDEAD_BEEF, 32'd3, -1, 0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      rx = $urandom;
      case ($urandom_range(0, 4))
        0:       ry = 32'd0;
        1:       ry = $urandom_range(1, 15);
        2:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rx = 32'h8000_0000;
      run_op(ro, rx, ry, -1, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
